// File: rtl/seven_seg_pkg.sv
// Shared segment-bus definitions for the seven-segment scan driver.
// Segment order is {a,b,c,d,e,f,g}; all codes are active-low (0 = lit).
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0   = 7'b0000001;
  localparam seg_t SEG_1   = 7'b1001111;
  localparam seg_t SEG_2   = 7'b0010010;
  localparam seg_t SEG_3   = 7'b0000110;
  localparam seg_t SEG_4   = 7'b1001100;
  localparam seg_t SEG_5   = 7'b0100100;
  localparam seg_t SEG_6   = 7'b0100000;
  localparam seg_t SEG_7   = 7'b0001111;
  localparam seg_t SEG_8   = 7'b0000000;
  localparam seg_t SEG_9   = 7'b0000100;
  localparam seg_t SEG_OFF = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-decimal codes (10..15) produce a dark digit.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0]       bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  // Map each BCD code to its segment pattern.
  always_comb begin
    seg_o = SEG_OFF;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered BCD value,
// leading-zero blanking, per-digit blink and decimal point, and a short
// all-anodes-off interval at the start of each digit slot to avoid ghosting.
// All outputs are registered and lag the scan state by one cycle.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES  = 16,
  parameter int unsigned BLINK_FRAMES  = 64,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(NUM_DIGITS);
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = AN_ACTIVE_LOW ? '1 : '0;

  logic [SW-1:0]           slot_q, slot_d;
  logic [DW-1:0]           dig_q, dig_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic                    blink_q, blink_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;

  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    ft_q, ft_d;

  logic                    slot_last, dig_last, frame_end, active;
  logic [3:0]              cur_bcd;
  logic                    cur_dp, cur_blink, cur_lz;
  logic [NUM_DIGITS-1:0]   lz_mask, an_hot;
  logic                    seen_nz;
  logic [SEG_W-1:0]        dec_seg;

  assign slot_last = (slot_q == SW'(SCAN_DIV - 1));
  assign dig_last  = (dig_q == DW'(NUM_DIGITS - 1));
  assign frame_end = slot_last & dig_last;
  assign active    = (slot_q >= SW'(BLANK_CYCLES));

  // Scan position, blink phase and the shadow/display double buffer.
  always_comb begin
    slot_d   = slot_last ? '0 : slot_q + 1'b1;
    dig_d    = dig_q;
    fcnt_d   = fcnt_q;
    blink_d  = blink_q;
    shadow_d = load ? bcd_in : shadow_q;
    disp_d   = disp_q;
    if (slot_last) begin
      dig_d = dig_last ? '0 : dig_q + 1'b1;
    end
    if (frame_end) begin
      // A load coinciding with the boundary bypasses the shadow so the
      // new value is not delayed by a whole frame.
      disp_d = load ? bcd_in : shadow_q;
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Leading-zero mask: walk from the top digit down until a nonzero digit.
  always_comb begin
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      seen_nz = seen_nz | (disp_q[4*(NUM_DIGITS-1-k) +: 4] != 4'd0);
      lz_mask[NUM_DIGITS-1-k] = blank_lz & ~seen_nz & ((NUM_DIGITS-1-k) != 0);
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    an_hot    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (DW'(k) == dig_q) begin
        cur_bcd   = disp_q[4*k +: 4];
        cur_dp    = dp_mask[k];
        cur_blink = blink_mask[k];
        cur_lz    = lz_mask[k];
        an_hot[k] = active;
      end
    end
  end

  bcd_to_seg u_dec (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

  // Next values for the registered display outputs.
  always_comb begin
    an_d = AN_ACTIVE_LOW ? ~an_hot : an_hot;
    ft_d = frame_end;
    if (!active || cur_lz || (blink_q && cur_blink)) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = dec_seg;
    end
    if (!active || (blink_q && cur_blink)) begin
      dp_d = 1'b1;
    end else begin
      dp_d = ~cur_dp;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      dig_q    <= '0;
      fcnt_q   <= '0;
      blink_q  <= 1'b0;
      shadow_q <= '0;
      disp_q   <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      an_q     <= AN_IDLE;
      ft_q     <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      dig_q    <= dig_d;
      fcnt_q   <= fcnt_d;
      blink_q  <= blink_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      ft_q     <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized self-checking bench for seven_seg_scan_driver (4 digits,
// 8-cycle slots, 2 blank cycles, 2-frame blink half-period).
module tb_seven_seg_scan_driver;

  localparam int ND    = 4;
  localparam int SDIV  = 8;
  localparam int BLNK  = 2;
  localparam int BFR   = 2;
  localparam int FRAME = ND * SDIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   bcd_in = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic [3:0]    blink_mask = '0;
  logic [3:0]    dp_mask = '0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_tick;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state: scan-state index since reset release, buffers,
  // and number of frame boundaries seen.
  int unsigned m_t;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;
  int unsigned m_frames;

  seven_seg_scan_driver #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV      (SDIV),
    .BLANK_CYCLES  (BLNK),
    .BLINK_FRAMES  (BFR),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, state %0d)", tag, got, exp, $time, m_t);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_t      = 0;
    m_shadow = '0;
    m_disp   = '0;
    m_frames = 0;
  endtask

  // One clock: drive inputs, predict outputs from the model, compare, advance.
  task automatic step(input logic ld, input logic [15:0] val);
    int unsigned slot, dg;
    logic        last, phase, lz, blinked, act;
    logic [3:0]  d;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    @(negedge clk);
    load   = ld;
    bcd_in = val;
    slot    = m_t % SDIV;
    dg      = (m_t / SDIV) % ND;
    last    = (m_t % FRAME) == FRAME - 1;
    act     = slot >= BLNK;
    phase   = ((m_frames / BFR) % 2) == 1;
    d       = 4'((m_disp >> (4 * dg)) & 16'hF);
    lz      = blank_lz && dg != 0 && (m_disp >> (4 * dg)) == 0;
    blinked = phase && blink_mask[dg];
    e_seg   = (lz || blinked) ? 7'h7F : seg_ref(d);
    e_dp    = act ? (blinked ? 1'b1 : ~dp_mask[dg]) : 1'b1;
    e_an    = act ? ~(4'b0001 << dg) : 4'hF;
    @(posedge clk);
    #1;
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("dp", 32'(dp), 32'(e_dp));
    check_eq("frame_tick", 32'(frame_tick), 32'(last));
    if (act) check_eq("seg", 32'(seg), 32'(e_seg));
    if (last) begin
      m_disp = ld ? val : m_shadow;
      m_frames++;
    end
    if (ld) m_shadow = val;
    m_t++;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
    check_eq({tag, "_dp"}, 32'(dp), 32'h1);
    check_eq({tag, "_an"}, 32'(an), 32'hF);
    check_eq({tag, "_ft"}, 32'(frame_tick), 32'h0);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic scan of 1234, including the all-zero frame before it takes effect.
    step(1'b1, 16'h1234);
    run(3 * FRAME);

    // Mid-frame load shows only from the next frame.
    while (m_t % FRAME != 12) step(1'b0, 16'h0);
    step(1'b1, 16'h5678);
    run(2 * FRAME);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    step(1'b1, 16'h0042);
    run(2 * FRAME);
    step(1'b1, 16'h0000);
    run(2 * FRAME);
    step(1'b1, 16'h9ABC);
    run(2 * FRAME);
    blank_lz = 1'b0;
    step(1'b1, 16'h9ABC);
    run(2 * FRAME);

    // Blink and decimal point.
    step(1'b1, 16'h1234);
    blink_mask = 4'b0001;
    dp_mask    = 4'b0010;
    run(9 * FRAME);

    // Load exactly on the frame boundary cycle.
    while (m_t % FRAME != FRAME - 1) step(1'b0, 16'h0);
    step(1'b1, 16'h8765);
    run(FRAME + 4);

    // Randomized traffic with live mask changes.
    for (int unsigned i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 40) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 30) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 20) == 0) dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) step(1'b1, rand_bcd());
      else                            step(1'b0, rand_bcd());
    end

    // Asynchronous reset in digit slot 2, cycle 5.
    while (m_t % FRAME != 2 * SDIV + 5) step(1'b0, 16'h0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 check_reset_outputs("held_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    blink_mask = '0;
    run(2 * FRAME);
    step(1'b1, 16'h4321);
    run(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
